// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_unit
// Brief   : Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU,
//           valid/ready request and response channels, one quotient bit/cycle.
// Revision: 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_div_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_div_data
);

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_rem;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sel_rem;
    logic                 r_q_neg;
    logic                 r_r_neg;
    logic [WIDTH-1:0]     r_data;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic                 w_special;
    logic [WIDTH-1:0]     w_special_data;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_remd;

    assign w_accept   = i_valid && (r_state == S_IDLE);
    assign w_signed   = ~i_div_op[0];
    assign w_a_neg    = w_signed & i_operand_a[WIDTH-1];
    assign w_b_neg    = w_signed & i_operand_b[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -i_operand_a : i_operand_a;
    assign w_b_abs    = w_b_neg ? -i_operand_b : i_operand_b;
    assign w_div_zero = (i_operand_b == '0);
    assign w_ovf      = w_signed && (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                        && (i_operand_b == '1);
    assign w_special  = w_div_zero | w_ovf;

    // Overflow quotient equals the dividend itself (most negative value).
    assign w_special_data = i_div_op[1] ? (w_div_zero ? i_operand_a : '0)
                                        : (w_div_zero ? '1 : i_operand_a);

    // Partial remainder widened by one bit so divisors >= 2^(WIDTH-1) work.
    assign w_trial = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});

    assign w_quot = r_q_neg ? -r_dvd : r_dvd;
    assign w_remd = r_r_neg ? -r_rem : r_rem;

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = (r_state == S_DONE);
    assign o_div_data = r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == c_LAST) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd     <= w_a_abs;
                        r_dvs     <= w_b_abs;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_sel_rem <= i_div_op[1];
                        r_q_neg   <= w_a_neg ^ w_b_neg;
                        r_r_neg   <= w_a_neg;
                        if (w_special) begin
                            r_data <= w_special_data;
                        end
                    end
                end
                S_CALC: begin
                    // Dividend register shifts out dividend bits and in quotient bits.
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_FIX: begin
                    r_data <= r_sel_rem ? w_remd : w_quot;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
